// File: rtl/mips_run_monitor.sv
// Run controller/checker for mips_pipeline: sequences the core reset, runs it for a
// bounded number of cycles and reports pass/timeout with a cycle count and captured result.
module mips_run_monitor #(
    parameter int WIDTH         = 32,
    parameter int RESET_CYCLES  = 2,
    parameter int RUN_CYCLES    = 20,
    parameter int STABLE_CYCLES = 3,
    parameter int CW            = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] expected,
    input  logic [WIDTH-1:0] dut_result,
    output logic             dut_rst,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic [CW-1:0]    cycles,
    output logic [WIDTH-1:0] captured
);

    localparam int RW = (RESET_CYCLES  < 2) ? 1 : $clog2(RESET_CYCLES + 1);
    localparam int SW = (STABLE_CYCLES < 2) ? 1 : $clog2(STABLE_CYCLES + 1);
    localparam logic [RW-1:0] RST_LAST   = RW'(RESET_CYCLES - 1);
    localparam logic [SW-1:0] STABLE_TGT = SW'(STABLE_CYCLES);
    localparam logic [CW-1:0] RUN_TGT    = CW'(RUN_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_RESET, S_RUN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [RW-1:0]    rcnt_q, rcnt_d;
    logic [SW-1:0]    stable_q, stable_d;
    logic [WIDTH-1:0] exp_q, exp_d;
    logic [CW-1:0]    cycles_q, cycles_d;
    logic [WIDTH-1:0] captured_q, captured_d;
    logic             pass_q, pass_d;
    logic             timeout_q, timeout_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             dut_rst_q, dut_rst_d;

    logic [CW-1:0]    cyc_inc;
    logic [SW-1:0]    stable_inc;
    logic             match;

    always_comb begin
        state_d    = state_q;
        rcnt_d     = rcnt_q;
        stable_d   = stable_q;
        exp_d      = exp_q;
        cycles_d   = cycles_q;
        captured_d = captured_q;
        pass_d     = pass_q;
        timeout_d  = timeout_q;
        done_d     = done_q;
        busy_d     = busy_q;
        dut_rst_d  = dut_rst_q;

        // Counter saturates rather than wrapping so an oversized run never reports a small count.
        cyc_inc    = (cycles_q == '1) ? cycles_q : cycles_q + 1'b1;
        stable_inc = stable_q + 1'b1;
        match      = (dut_result == exp_q);

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d    = S_RESET;
                    exp_d      = expected;
                    rcnt_d     = '0;
                    stable_d   = '0;
                    cycles_d   = '0;
                    captured_d = '0;
                    pass_d     = 1'b0;
                    timeout_d  = 1'b0;
                    done_d     = 1'b0;
                    busy_d     = 1'b1;
                    dut_rst_d  = 1'b1;
                end
            end
            S_RESET: begin
                if (rcnt_q == RST_LAST) begin
                    state_d   = S_RUN;
                    dut_rst_d = 1'b0;
                end else begin
                    rcnt_d = rcnt_q + 1'b1;
                end
            end
            S_RUN: begin
                cycles_d = cyc_inc;
                stable_d = match ? stable_inc : '0;
                // Pass is tested first so a match landing on the last allowed cycle still passes.
                if (match && (stable_inc == STABLE_TGT)) begin
                    state_d    = S_DONE;
                    pass_d     = 1'b1;
                    done_d     = 1'b1;
                    busy_d     = 1'b0;
                    captured_d = dut_result;
                end else if (cyc_inc >= RUN_TGT) begin
                    state_d    = S_DONE;
                    timeout_d  = 1'b1;
                    done_d     = 1'b1;
                    busy_d     = 1'b0;
                    captured_d = dut_result;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            rcnt_q     <= '0;
            stable_q   <= '0;
            exp_q      <= '0;
            cycles_q   <= '0;
            captured_q <= '0;
            pass_q     <= 1'b0;
            timeout_q  <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            dut_rst_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            rcnt_q     <= rcnt_d;
            stable_q   <= stable_d;
            exp_q      <= exp_d;
            cycles_q   <= cycles_d;
            captured_q <= captured_d;
            pass_q     <= pass_d;
            timeout_q  <= timeout_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            dut_rst_q  <= dut_rst_d;
        end
    end

    assign dut_rst  = dut_rst_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign pass     = pass_q;
    assign timeout  = timeout_q;
    assign cycles   = cycles_q;
    assign captured = captured_q;

endmodule

// File: tb/tb_mips_run_monitor.sv
// Scoreboard bench for mips_run_monitor: stimulus pushes expected run outcomes, a negedge
// monitor pops and compares them whenever done rises.
module tb_mips_run_monitor;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [31:0] expected = '0;
    logic [31:0] dut_result = '0;
    logic        dut_rst, busy, done, pass, timeout;
    logic [15:0] cycles;
    logic [31:0] captured;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic        pass_e;
        logic        to_e;
        logic [15:0] cyc_e;
        logic [31:0] cap_e;
        int          rst_len_e;
    } exp_t;
    exp_t sb_q[$];

    mips_run_monitor dut (
        .clk(clk), .reset(reset), .start(start), .expected(expected),
        .dut_result(dut_result), .dut_rst(dut_rst), .busy(busy), .done(done),
        .pass(pass), .timeout(timeout), .cycles(cycles), .captured(captured)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Result the fake core presents on RUN cycle k for each scenario.
    function automatic logic [31:0] pat(input int mode, input int k);
        case (mode)
            0: return (k >= 4)  ? 32'hA  : 32'h0;
            1: return (k % 2)   ? 32'h5  : 32'h0;
            2: return (k >= 18) ? 32'h3C : 32'h0;
            3: return (k >= 2)  ? 32'h7  : 32'h1;
            default: return 32'h0;
        endcase
    endfunction

    // Monitor: counts cycles the core is held in reset and checks each completed run.
    int   rst_len = 0;
    logic done_prev = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            rst_len = 0;
        end else begin
            if (busy && dut_rst) rst_len++;
            if (done && !done_prev) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done: got done=1 expected no completion");
                end else begin
                    e = sb_q.pop_front();
                    chk("pass", {31'b0, pass}, {31'b0, e.pass_e});
                    chk("timeout", {31'b0, timeout}, {31'b0, e.to_e});
                    chk("cycles", {16'b0, cycles}, {16'b0, e.cyc_e});
                    chk("captured", captured, e.cap_e);
                    chk("rst_len", rst_len, e.rst_len_e);
                end
                rst_len = 0;
            end
        end
        done_prev = done;
    end

    task automatic do_run(input int mode, input logic [31:0] exp_val, input int k_max,
                          input bit will_finish, input exp_t e);
        expected = exp_val;
        start    = 1'b1;
        if (will_finish) sb_q.push_back(e);
        tick();
        start = 1'b0;
        chk("start_busy", {31'b0, busy}, 32'd1);
        chk("start_dut_rst", {31'b0, dut_rst}, 32'd1);
        chk("start_done_clr", {31'b0, done}, 32'd0);
        chk("start_pass_clr", {31'b0, pass}, 32'd0);
        chk("start_cycles_clr", {16'b0, cycles}, 32'd0);
        tick();
        tick();
        for (int k = 1; k <= k_max; k++) begin
            dut_result = pat(mode, k);
            if (mode == 3 && k == 3) begin
                start    = 1'b1;
                expected = 32'h1;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
        if (will_finish) begin
            tick();
            tick();
        end
    endtask

    initial begin
        exp_t e;
        // 1: reset then idle
        tick();
        chk("rst_dut_rst", {31'b0, dut_rst}, 32'd1);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        tick();
        reset = 1'b1;
        repeat (5) tick();
        chk("idle_dut_rst", {31'b0, dut_rst}, 32'd1);
        chk("idle_busy", {31'b0, busy}, 32'd0);
        chk("idle_done", {31'b0, done}, 32'd0);
        chk("idle_cycles", {16'b0, cycles}, 32'd0);
        chk("idle_captured", captured, 32'd0);

        // 2: pass on RUN cycle 6
        e = '{pass_e: 1'b1, to_e: 1'b0, cyc_e: 16'd6, cap_e: 32'hA, rst_len_e: 2};
        do_run(0, 32'hA, 6, 1'b1, e);

        // 3: toggling result never stabilises
        e = '{pass_e: 1'b0, to_e: 1'b1, cyc_e: 16'd20, cap_e: 32'h0, rst_len_e: 2};
        do_run(1, 32'h5, 20, 1'b1, e);

        // 4: third stable match lands on the last RUN cycle
        e = '{pass_e: 1'b1, to_e: 1'b0, cyc_e: 16'd20, cap_e: 32'h3C, rst_len_e: 2};
        do_run(2, 32'h3C, 20, 1'b1, e);

        // 5: restart from DONE, stray start and expected change during RUN ignored
        e = '{pass_e: 1'b1, to_e: 1'b0, cyc_e: 16'd4, cap_e: 32'h7, rst_len_e: 2};
        do_run(3, 32'h7, 4, 1'b1, e);
        chk("done_frozen", {31'b0, done}, 32'd1);
        chk("dut_rst_in_done", {31'b0, dut_rst}, 32'd0);

        // 6: asynchronous abort mid-RUN
        e = '{pass_e: 1'b0, to_e: 1'b0, cyc_e: 16'd0, cap_e: 32'h0, rst_len_e: 0};
        do_run(4, 32'h9, 5, 1'b0, e);
        chk("pre_abort_cycles", {16'b0, cycles}, 32'd5);
        #2;
        reset = 1'b0;
        #1;
        chk("abort_dut_rst", {31'b0, dut_rst}, 32'd1);
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_done", {31'b0, done}, 32'd0);
        chk("abort_cycles", {16'b0, cycles}, 32'd0);
        tick();
        reset = 1'b1;
        repeat (3) tick();
        chk("post_abort_busy", {31'b0, busy}, 32'd0);
        chk("post_abort_done", {31'b0, done}, 32'd0);

        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL sb_drain: got %0d pending runs expected 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before 100000");
        $fatal(1);
    end

endmodule
